iter_alu: RTL and testbench

- Parametrised sequential ALU; successor to the team's combinational N-bit function blocks (add/sub/mul/div/mod/logic).
- Single opcode-selected datapath with valid/ready handshakes on input and output.
- Logic, add and sub complete in one cycle. Multiply (shift-add) and divide/modulo (restoring) are iterative, one bit per cycle.
- Sits between the instruction/operand register stage and the result writeback in the calculator datapath.

---
 rtl/alu_pkg.sv | 36 +++
 rtl/iter_divmod.sv | 67 ++++++
 rtl/iter_alu.sv | 259 +++++++++++++++++++++++++
 tb/tb_iter_alu.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the iterative ALU (opcodes, FSM states, flag bundle).
// Counter widths are used only when ITER_ALU_OP_COUNTER_EN is defined.
package alu_pkg;

    localparam int OP_LAST = 8;
    localparam int CNT_W   = 16;
    localparam int ERR_W   = 8;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_MUL = 4'd2,
        OP_DIV = 4'd3,
        OP_MOD = 4'd4,
        OP_AND = 4'd5,
        OP_OR  = 4'd6,
        OP_XOR = 4'd7,
        OP_NOT = 4'd8
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } alu_state_t;

    typedef struct packed {
        logic zero;
        logic neg;
        logic carry;
        logic ovf;
        logic dbz;
        logic ill;
    } alu_flags_t;

endpackage

// File: rtl/iter_divmod.sv
// N-cycle restoring divider. done flags the final iteration; quotient/remainder
// carry the values that step produces, so the caller latches them on that edge.
module iter_divmod
    import alu_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder
);

    localparam int CW = $clog2(N + 1);

    logic [CW-1:0] cnt_r;
    logic [N-1:0]  rem_r;
    logic [N-1:0]  quo_r;
    logic [N-1:0]  div_r;
    logic [N:0]    shifted_s;
    logic [N:0]    diff_s;
    logic          ge_s;
    logic [N-1:0]  rem_next_s;
    logic [N-1:0]  quo_next_s;

    // One restoring step. The remainder stays below the divisor, so the trial
    // difference is negative exactly when its top bit is set.
    always_comb begin
        shifted_s = {rem_r, quo_r[N-1]};
        diff_s    = shifted_s - {1'b0, div_r};
        ge_s      = ~diff_s[N];
        if (ge_s) begin
            rem_next_s = diff_s[N-1:0];
        end else begin
            rem_next_s = shifted_s[N-1:0];
        end
        quo_next_s = {quo_r[N-2:0], ge_s};
    end

    assign done      = (cnt_r == CW'(1));
    assign quotient  = quo_next_s;
    assign remainder = rem_next_s;

    // Load operands on start, then iterate until the counter drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CW{1'b0}};
            rem_r <= {N{1'b0}};
            quo_r <= {N{1'b0}};
            div_r <= {N{1'b0}};
        end else if (start) begin
            cnt_r <= CW'(N);
            rem_r <= {N{1'b0}};
            quo_r <= dividend;
            div_r <= divisor;
        end else if (cnt_r != {CW{1'b0}}) begin
            cnt_r <= cnt_r - CW'(1);
            rem_r <= rem_next_s;
            quo_r <= quo_next_s;
        end
    end

endmodule

// File: rtl/iter_alu.sv
// Sequential opcode-selected ALU with valid/ready handshakes; MUL and DIV/MOD iterate one bit per cycle.
// Optional op/error counters are built when ITER_ALU_OP_COUNTER_EN is defined. Requires OPW >= 4.
module iter_alu
    import alu_pkg::*;
#(
    parameter int N   = 8,
    parameter int OPW = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [OPW-1:0] op,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    input  logic           c_in,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   result_lo,
    output logic [N-1:0]   result_hi,
    output logic           flag_zero,
    output logic           flag_neg,
    output logic           flag_carry,
    output logic           flag_ovf,
    output logic           flag_dbz,
    output logic           flag_ill
`ifdef ITER_ALU_OP_COUNTER_EN
    ,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] op_count,
    output logic [ERR_W-1:0] err_count
`endif
);

    localparam int CW = $clog2(N + 1);

    alu_state_t    state_r;
    logic [CW-1:0] cnt_r;
    logic          in_ready_r;
    logic          out_valid_r;
    logic [2*N-1:0] acc_r;
    logic [N-1:0]  mcand_r;
    logic          is_mul_r;
    logic          is_mod_r;
    logic [N-1:0]  lo_r;
    logic [N-1:0]  hi_r;
    alu_flags_t    flags_r;

    alu_op_t       op_s;
    logic          op_ill_s;
    logic          accept_s;
    logic          b_zero_s;
    logic          mul_start_s;
    logic          div_start_s;
    logic          iter_start_s;
    logic          mul_finish_s;
    logic          div_finish_s;
    logic [N:0]    add_sum_s;
    logic [N:0]    mul_sum_s;
    logic [2*N-1:0] mul_next_s;
    logic [N-1:0]  fast_lo_s;
    alu_flags_t    fast_flags_s;
    logic [N-1:0]  iter_lo_s;
    logic [N-1:0]  iter_hi_s;
    alu_flags_t    iter_flags_s;
    logic          div_done_s;
    logic [N-1:0]  quotient_s;
    logic [N-1:0]  remainder_s;

    assign op_s         = alu_op_t'(op[3:0]);
    assign op_ill_s     = (op > OPW'(OP_LAST));
    assign accept_s     = in_valid && (state_r == IDLE);
    assign b_zero_s     = (b == {N{1'b0}});
    assign mul_start_s  = accept_s && !op_ill_s && (op_s == OP_MUL);
    assign div_start_s  = accept_s && !op_ill_s && ((op_s == OP_DIV) || (op_s == OP_MOD)) && !b_zero_s;
    assign iter_start_s = mul_start_s || div_start_s;
    assign mul_finish_s = (state_r == BUSY) && is_mul_r && (cnt_r == CW'(1));
    assign div_finish_s = (state_r == BUSY) && !is_mul_r && div_done_s;

    assign add_sum_s  = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c_in};
    // Shift-add: {hi, lo} starts as {0, b}; each step adds a into hi when lo[0] is set, then shifts right.
    assign mul_sum_s  = {1'b0, acc_r[2*N-1:N]} + (acc_r[0] ? {1'b0, mcand_r} : {(N+1){1'b0}});
    assign mul_next_s = {mul_sum_s, acc_r[N-1:1]};

    iter_divmod #(
        .N(N)
    ) u_divmod (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (div_start_s),
        .dividend  (a),
        .divisor   (b),
        .done      (div_done_s),
        .quotient  (quotient_s),
        .remainder (remainder_s)
    );

    // Single-cycle result for ADD/SUB/logic, divide-by-zero and illegal opcodes.
    always_comb begin
        fast_lo_s    = {N{1'b0}};
        fast_flags_s = '{default: 1'b0};
        if (op_ill_s) begin
            fast_flags_s.ill = 1'b1;
        end else begin
            case (op_s)
                OP_ADD: begin
                    fast_lo_s          = add_sum_s[N-1:0];
                    fast_flags_s.carry = add_sum_s[N];
                end
                OP_SUB: begin
                    fast_lo_s        = a - b;
                    fast_flags_s.neg = (b > a);
                end
                OP_MUL:         fast_lo_s        = {N{1'b0}};
                OP_DIV, OP_MOD: fast_flags_s.dbz = b_zero_s;
                OP_AND:         fast_lo_s        = a & b;
                OP_OR:          fast_lo_s        = a | b;
                OP_XOR:         fast_lo_s        = a ^ b;
                OP_NOT:         fast_lo_s        = ~a;
                default:        fast_flags_s.ill = 1'b1;
            endcase
        end
        fast_flags_s.zero = !fast_flags_s.ill && (fast_lo_s == {N{1'b0}});
    end

    // Result of the final iteration of MUL or DIV/MOD.
    always_comb begin
        iter_flags_s = '{default: 1'b0};
        if (is_mul_r) begin
            iter_lo_s         = mul_next_s[N-1:0];
            iter_hi_s         = mul_next_s[2*N-1:N];
            iter_flags_s.ovf  = (mul_next_s[2*N-1:N] != {N{1'b0}});
            iter_flags_s.zero = (mul_next_s == {(2*N){1'b0}});
        end else begin
            iter_lo_s         = is_mod_r ? remainder_s : quotient_s;
            iter_hi_s         = {N{1'b0}};
            iter_flags_s.zero = (iter_lo_s == {N{1'b0}});
        end
    end

    // Control FSM with registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= {CW{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        in_ready_r <= 1'b0;
                        if (iter_start_s) begin
                            state_r <= BUSY;
                            cnt_r   <= CW'(N);
                        end else begin
                            state_r     <= DONE;
                            out_valid_r <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (cnt_r != {CW{1'b0}}) begin
                        cnt_r <= cnt_r - CW'(1);
                    end
                    if (mul_finish_s || div_finish_s) begin
                        state_r     <= DONE;
                        out_valid_r <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_r     <= IDLE;
                        in_ready_r  <= 1'b1;
                        out_valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    cnt_r       <= {CW{1'b0}};
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Operand capture and the multiply accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r    <= {(2*N){1'b0}};
            mcand_r  <= {N{1'b0}};
            is_mul_r <= 1'b0;
            is_mod_r <= 1'b0;
        end else if (accept_s) begin
            acc_r    <= {{N{1'b0}}, b};
            mcand_r  <= a;
            is_mul_r <= (op_s == OP_MUL);
            is_mod_r <= (op_s == OP_MOD);
        end else if ((state_r == BUSY) && is_mul_r) begin
            acc_r <= mul_next_s;
        end
    end

    // Result registers, held stable through DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_r    <= {N{1'b0}};
            hi_r    <= {N{1'b0}};
            flags_r <= '{default: 1'b0};
        end else if (accept_s && !iter_start_s) begin
            lo_r    <= fast_lo_s;
            hi_r    <= {N{1'b0}};
            flags_r <= fast_flags_s;
        end else if (mul_finish_s || div_finish_s) begin
            lo_r    <= iter_lo_s;
            hi_r    <= iter_hi_s;
            flags_r <= iter_flags_s;
        end
    end

    assign in_ready   = in_ready_r;
    assign out_valid  = out_valid_r;
    assign result_lo  = lo_r;
    assign result_hi  = hi_r;
    assign flag_zero  = flags_r.zero;
    assign flag_neg   = flags_r.neg;
    assign flag_carry = flags_r.carry;
    assign flag_ovf   = flags_r.ovf;
    assign flag_dbz   = flags_r.dbz;
    assign flag_ill   = flags_r.ill;

`ifdef ITER_ALU_OP_COUNTER_EN
    logic [CNT_W-1:0] op_count_r;
    logic [ERR_W-1:0] err_count_r;

    // Saturating handshake and error counters; clear wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count_r  <= {CNT_W{1'b0}};
            err_count_r <= {ERR_W{1'b0}};
        end else if (cnt_clr) begin
            op_count_r  <= {CNT_W{1'b0}};
            err_count_r <= {ERR_W{1'b0}};
        end else if (out_valid_r && out_ready) begin
            if (op_count_r != {CNT_W{1'b1}}) begin
                op_count_r <= op_count_r + CNT_W'(1);
            end
            if ((flags_r.dbz || flags_r.ill) && (err_count_r != {ERR_W{1'b1}})) begin
                err_count_r <= err_count_r + ERR_W'(1);
            end
        end
    end

    assign op_count  = op_count_r;
    assign err_count = err_count_r;
`endif

endmodule

// File: tb/tb_iter_alu.sv
// Scoreboard bench for iter_alu (N=8): expectations pushed at drive time, popped at out_valid.
module tb_iter_alu;

    localparam int N   = 8;
    localparam int OPW = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [OPW-1:0] op = '0;
    logic [N-1:0]   a = '0;
    logic [N-1:0]   b = '0;
    logic           c_in = 1'b0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [N-1:0]   result_lo;
    logic [N-1:0]   result_hi;
    logic flag_zero, flag_neg, flag_carry, flag_ovf, flag_dbz, flag_ill;
`ifdef ITER_ALU_OP_COUNTER_EN
    logic        cnt_clr = 1'b0;
    logic [15:0] op_count;
    logic [7:0]  err_count;
`endif

    iter_alu #(.N(N), .OPW(OPW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .c_in(c_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .result_lo(result_lo), .result_hi(result_hi),
        .flag_zero(flag_zero), .flag_neg(flag_neg), .flag_carry(flag_carry),
        .flag_ovf(flag_ovf), .flag_dbz(flag_dbz), .flag_ill(flag_ill)
`ifdef ITER_ALU_OP_COUNTER_EN
        , .cnt_clr(cnt_clr), .op_count(op_count), .err_count(err_count)
`endif
    );

    always #5 clk = ~clk;

    // fl = {zero, neg, carry, ovf, dbz, ill}
    typedef struct packed {
        logic [N-1:0] lo;
        logic [N-1:0] hi;
        logic [5:0]   fl;
    } res_t;

    typedef struct {
        res_t  r;
        int    lat;
        string name;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass = 0;

    function automatic res_t model(int opc, int x, int y, int ci);
        res_t r;
        int   s;
        r = '0;
        case (opc)
            0: begin s = x + y + ci; r.lo = N'(s); r.fl[3] = (s >= (1 << N)); end
            1: begin r.lo = N'(x - y); r.fl[4] = (y > x); end
            2: begin
                s = x * y;
                r.lo = N'(s); r.hi = N'(s >> N);
                r.fl[2] = (s >= (1 << N)); r.fl[5] = (s == 0);
            end
            3: if (y == 0) r.fl[1] = 1'b1; else r.lo = N'(x / y);
            4: if (y == 0) r.fl[1] = 1'b1; else r.lo = N'(x % y);
            5: r.lo = N'(x & y);
            6: r.lo = N'(x | y);
            7: r.lo = N'(x ^ y);
            8: r.lo = N'(~x);
            default: r.fl[0] = 1'b1;
        endcase
        if (opc != 2 && opc <= 8) r.fl[5] = (r.lo == '0);
        return r;
    endfunction

    function automatic int exp_lat(int opc, int y);
        return (opc == 2 || ((opc == 3 || opc == 4) && y != 0)) ? N + 1 : 1;
    endfunction

    function automatic res_t cur();
        return {result_lo, result_hi, flag_zero, flag_neg, flag_carry, flag_ovf, flag_dbz, flag_ill};
    endfunction

    // Called just after a negedge with in_ready high; returns at the first negedge after acceptance.
    task automatic send(input int opc, input int x, input int y, input int ci, input string name);
        exp_t e;
        op = OPW'(opc); a = N'(x); b = N'(y); c_in = 1'(ci); in_valid = 1'b1;
        e.r = model(opc, x, y, ci); e.lat = exp_lat(opc, y); e.name = name;
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int cyc);
        cyc = 1;
        while (!out_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({in_ready, out_valid} !== 2'b10) $display("FAIL reset_hs: got ready/valid=%b expected 10", {in_ready, out_valid});
        else n_pass++;
        n_checks++;
        if (cur() !== res_t'(0)) $display("FAIL reset_out: got %h expected 0", cur());
        else n_pass++;
`ifdef ITER_ALU_OP_COUNTER_EN
        n_checks++;
        if ({op_count, err_count} !== 24'd0) $display("FAIL reset_cnt: got %0d/%0d expected 0/0", op_count, err_count);
        else n_pass++;
`endif
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add_hold();
        exp_t e;
        int   cyc;
        send(0, 200, 100, 1, "add_hold");
        wait_out(cyc);
        e = sb_q.pop_front();
        n_checks++;
        if (cyc !== e.lat) $display("FAIL %s latency: got %0d expected %0d", e.name, cyc, e.lat);
        else n_pass++;
        n_checks++;
        if (cur() !== e.r) $display("FAIL %s result: got %h expected %h", e.name, cur(), e.r);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if ({out_valid, in_ready, cur()} !== {1'b1, 1'b0, e.r})
                $display("FAIL %s held%0d: got v=%b r=%b %h expected v=1 r=0 %h", e.name, i, out_valid, in_ready, cur(), e.r);
            else n_pass++;
        end
        take();
    endtask

    task automatic test_arith();
        int tbl[15][4] = '{
            '{1, 5, 9, 0}, '{1, 7, 7, 0}, '{3, 100, 7, 0}, '{4, 100, 7, 0},
            '{3, 3, 0, 0}, '{4, 3, 0, 0}, '{3, 3, 9, 0}, '{4, 3, 9, 0},
            '{5, 240, 60, 0}, '{6, 240, 15, 0}, '{7, 85, 85, 0}, '{8, 255, 0, 0},
            '{12, 3, 4, 0}, '{9, 1, 1, 1}, '{2, 0, 77, 0}
        };
        exp_t e;
        int   cyc;
        for (int i = 0; i < 15; i++) begin
            send(tbl[i][0], tbl[i][1], tbl[i][2], tbl[i][3], $sformatf("arith%0d_op%0d", i, tbl[i][0]));
            wait_out(cyc);
            e = sb_q.pop_front();
            n_checks++;
            if (cyc !== e.lat) $display("FAIL %s latency: got %0d expected %0d", e.name, cyc, e.lat);
            else n_pass++;
            n_checks++;
            if (cur() !== e.r) $display("FAIL %s result: got %h expected %h", e.name, cur(), e.r);
            else n_pass++;
            take();
        end
    endtask

    task automatic test_mul();
        exp_t e;
        int   cyc;
        int   bad;
        send(2, 25, 12, 0, "mul_25x12");
        cyc = 1;
        bad = 0;
        while (!out_valid && cyc < 40) begin
            if (in_ready) bad++;
            @(negedge clk);
            cyc++;
        end
        e = sb_q.pop_front();
        n_checks++;
        if (cyc !== e.lat) $display("FAIL %s latency: got %0d expected %0d", e.name, cyc, e.lat);
        else n_pass++;
        n_checks++;
        if (bad !== 0) $display("FAIL %s busy_ready: got %0d cycles with in_ready expected 0", e.name, bad);
        else n_pass++;
        n_checks++;
        if (cur() !== e.r) $display("FAIL %s result: got %h expected %h", e.name, cur(), e.r);
        else n_pass++;
        take();
    endtask

    task automatic test_busy_drop();
        exp_t e;
        int   cyc;
        send(2, 3, 5, 0, "busy_drop");
        cyc = 1;
        while (!out_valid && cyc < 40) begin
            in_valid = (cyc >= 2 && cyc <= 4);
            op = '0; a = 8'd9; b = 8'd9;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        e = sb_q.pop_front();
        n_checks++;
        if (cyc !== e.lat) $display("FAIL %s latency: got %0d expected %0d", e.name, cyc, e.lat);
        else n_pass++;
        n_checks++;
        if (cur() !== e.r) $display("FAIL %s result: got %h expected %h", e.name, cur(), e.r);
        else n_pass++;
        take();
        repeat (2) @(negedge clk);
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01) $display("FAIL %s dropped: got valid/ready=%b expected 01", e.name, {out_valid, in_ready});
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int   ops[4][3] = '{'{1, 2, 0}, '{250, 10, 0}, '{0, 0, 0}, '{128, 128, 1}};
        exp_t e;
        int   sent = 0;
        int   nres = 0;
        int   last_t = 0;
        bit   acc;
        out_ready = 1'b1;
        op = '0; a = N'(ops[0][0]); b = N'(ops[0][1]); c_in = 1'(ops[0][2]); in_valid = 1'b1;
        e.r = model(0, ops[0][0], ops[0][1], ops[0][2]); e.lat = 1; e.name = "b2b0";
        sb_q.push_back(e);
        for (int t = 0; t < 40 && nres < 4; t++) begin
            if (out_valid) begin
                e = sb_q.pop_front();
                n_checks++;
                if (cur() !== e.r) $display("FAIL %s result: got %h expected %h", e.name, cur(), e.r);
                else n_pass++;
                if (nres > 0) begin
                    n_checks++;
                    if (t - last_t !== 2) $display("FAIL %s spacing: got %0d expected 2", e.name, t - last_t);
                    else n_pass++;
                end
                last_t = t;
                nres++;
            end
            acc = in_ready && in_valid;
            @(negedge clk);
            if (acc) begin
                sent++;
                if (sent < 4) begin
                    a = N'(ops[sent][0]); b = N'(ops[sent][1]); c_in = 1'(ops[sent][2]);
                    e.r = model(0, ops[sent][0], ops[sent][1], ops[sent][2]); e.lat = 1;
                    e.name = $sformatf("b2b%0d", sent);
                    sb_q.push_back(e);
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        out_ready = 1'b0;
        in_valid = 1'b0;
        n_checks++;
        if (nres !== 4) $display("FAIL b2b_count: got %0d results expected 4", nres);
        else n_pass++;
    endtask

    task automatic test_random();
        exp_t e;
        int   cyc, opc, x, y;
        for (int i = 0; i < 20; i++) begin
            opc = $urandom_range(0, 15);
            x = $urandom_range(0, 255);
            y = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 255);
            send(opc, x, y, $urandom_range(0, 1), $sformatf("rand%0d_op%0d_%0d_%0d", i, opc, x, y));
            wait_out(cyc);
            e = sb_q.pop_front();
            n_checks++;
            if (cyc !== e.lat) $display("FAIL %s latency: got %0d expected %0d", e.name, cyc, e.lat);
            else n_pass++;
            n_checks++;
            if (cur() !== e.r) $display("FAIL %s result: got %h expected %h", e.name, cur(), e.r);
            else n_pass++;
            take();
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   cyc;
        send(2, 25, 12, 0, "mul_aborted");
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01) $display("FAIL reset_mid: got valid/ready=%b expected 01", {out_valid, in_ready});
        else n_pass++;
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
`ifdef ITER_ALU_OP_COUNTER_EN
        n_checks++;
        if ({op_count, err_count} !== 24'd0) $display("FAIL cnt_after_rst: got %0d/%0d expected 0/0", op_count, err_count);
        else n_pass++;
`endif
        send(0, 1, 1, 0, "add_after_rst");
        wait_out(cyc);
        e = sb_q.pop_front();
        n_checks++;
        if (cyc !== e.lat) $display("FAIL %s latency: got %0d expected %0d", e.name, cyc, e.lat);
        else n_pass++;
        n_checks++;
        if (cur() !== e.r) $display("FAIL %s result: got %h expected %h", e.name, cur(), e.r);
        else n_pass++;
        take();
`ifdef ITER_ALU_OP_COUNTER_EN
        n_checks++;
        if ({op_count, err_count} !== {16'd1, 8'd0}) $display("FAIL cnt_after_add: got %0d/%0d expected 1/0", op_count, err_count);
        else n_pass++;
`endif
    endtask

    initial begin
        test_reset();
        test_add_hold();
        test_arith();
        test_mul();
        test_busy_drop();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule
